// File: rtl/halfword_mem_unit.sv
// halfword_mem_unit: lh/sh memory stage over a req/ack 32-bit word bus,
// with pipeline stall, sign-extended loads, misalignment detection and bus timeout.
module halfword_mem_unit #(
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] aluResult,
  input  logic [31:0] writeData,
  output logic        stall,
  output logic [31:0] loadData,
  output logic        loadValid,
  output logic        misaligned,
  output logic        busError,
  output logic        busReq,
  output logic        busWe,
  output logic [31:0] busAddr,
  output logic [3:0]  busByteEn,
  output logic [31:0] busWData,
  input  logic [31:0] busRData,
  input  logic        busAck
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT - 1);
  state_t                state_q, state_d;
  logic [29:0]           word_q, word_d;
  logic [3:0]            be_q, be_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]           load_data_q, load_data_d;
  logic                  load_valid_q, load_valid_d;
  logic                  misaligned_q, misaligned_d;
  logic                  bus_error_q, bus_error_d;
  logic                  idle, in_req, req, go, expire, rd_done;
  logic [15:0]           half;
  logic                  unused_hi;
  assign unused_hi = ^writeData[31:16];
  always_comb begin
    idle    = state_q == IDLE;
    in_req  = state_q == REQ;
    req     = memRead | memWrite;
    go      = idle & req & ~aluResult[0];
    expire  = in_req & ~busAck & (cnt_q == LAST);
    rd_done = in_req & busAck & ~we_q;
    half    = be_q[3] ? busRData[31:16] : busRData[15:0];
    state_d = (state_q == DONE) ? IDLE
            : in_req ? (busAck ? DONE : (expire ? IDLE : REQ))
            : (go ? REQ : IDLE);
    word_d  = go ? aluResult[31:2] : word_q;
    be_d    = go ? (aluResult[1] ? 4'b1100 : 4'b0011) : be_q;
    wdata_d = go ? writeData[15:0] : wdata_q;
    we_d    = go ? ~memRead : we_q;
    // expire fires before the counter can reach its top value, so no wrap
    cnt_d   = go ? '0 : ((in_req & ~busAck & ~expire) ? cnt_q + TIMEOUT_W'(1) : cnt_q);
    load_data_d  = rd_done ? {{16{half[15]}}, half} : load_data_q;
    load_valid_d = rd_done;
    misaligned_d = idle & req & aluResult[0];
    bus_error_d  = expire;
  end
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      word_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      misaligned_q <= misaligned_d;
      bus_error_q  <= bus_error_d;
    end
  end
  always_comb begin
    stall      = in_req | go;
    loadData   = load_data_q;
    loadValid  = load_valid_q;
    misaligned = misaligned_q;
    busError   = bus_error_q;
    busReq     = in_req;
    busWe      = we_q;
    busAddr    = {word_q, 2'b00};
    busByteEn  = be_q;
    busWData   = {wdata_q, wdata_q};
  end
endmodule

// File: tb/tb_halfword_mem_unit.sv
// tb_halfword_mem_unit: directed bench with a load-result scoreboard.
module tb_halfword_mem_unit;
  logic        clock = 1'b0;
  logic        resetN;
  logic        memRead, memWrite;
  logic [31:0] aluResult, writeData;
  logic        stall;
  logic [31:0] loadData;
  logic        loadValid, misaligned, busError, busReq, busWe;
  logic [31:0] busAddr;
  logic [3:0]  busByteEn;
  logic [31:0] busWData, busRData;
  logic        busAck;
  int          total = 0;
  int          passed = 0;
  logic [31:0] exp_q[$];

  halfword_mem_unit #(.TIMEOUT(4), .TIMEOUT_W(8)) dut (
    .clock(clock), .resetN(resetN), .memRead(memRead), .memWrite(memWrite),
    .aluResult(aluResult), .writeData(writeData), .stall(stall),
    .loadData(loadData), .loadValid(loadValid), .misaligned(misaligned),
    .busError(busError), .busReq(busReq), .busWe(busWe), .busAddr(busAddr),
    .busByteEn(busByteEn), .busWData(busWData), .busRData(busRData),
    .busAck(busAck)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic pop_load(input string tag);
    chk({tag, "_sb_pending"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) chk({tag, "_loadData"}, loadData, exp_q.pop_front());
  endtask

  initial begin
    int n;
    resetN = 1'b0; memRead = 0; memWrite = 0; aluResult = 0; writeData = 0;
    busRData = 0; busAck = 0;
    #12;
    chk("rst_busReq", 32'(busReq), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_loadData", loadData, 0);
    chk("rst_pulses", {29'd0, loadValid, misaligned, busError}, 0);
    chk("rst_bus", busAddr | busWData | {28'd0, busByteEn} | {31'd0, busWe}, 0);
    resetN = 1'b1;
    step();

    // lh 0x102, ack on first REQ cycle
    memRead = 1; aluResult = 32'h102; busRData = 32'h8001_1234;
    #1 chk("lh_stall_t", 32'(stall), 1);
    exp_q.push_back(32'hFFFF_8001);
    step();
    memRead = 0; aluResult = 0;
    chk("lh_busReq", 32'(busReq), 1);
    chk("lh_busAddr", busAddr, 32'h100);
    chk("lh_byteEn", 32'(busByteEn), 32'hC);
    chk("lh_busWe", 32'(busWe), 0);
    busAck = 1;
    #1 chk("lh_stall_t1", 32'(stall), 1);
    step();
    busAck = 0;
    chk("lh_loadValid", 32'(loadValid), 1);
    chk("lh_stall_t2", 32'(stall), 0);
    chk("lh_busReq_done", 32'(busReq), 0);
    pop_load("lh");
    step();
    chk("lh_loadValid_drop", 32'(loadValid), 0);

    // sh 0x200, three wait cycles then ack
    memWrite = 1; aluResult = 32'h200; writeData = 32'hABCD_5678;
    step();
    memWrite = 0; aluResult = 0; writeData = 0;
    chk("sh_busWe", 32'(busWe), 1);
    chk("sh_busAddr", busAddr, 32'h200);
    chk("sh_byteEn", 32'(busByteEn), 32'h3);
    chk("sh_busWData", busWData, 32'h5678_5678);
    step();
    step();
    chk("sh_busReq_wait", 32'(busReq), 1);
    chk("sh_stall_wait", 32'(stall), 1);
    step();
    chk("sh_busReq_last", 32'(busReq), 1);
    busAck = 1;
    step();
    busAck = 0;
    chk("sh_done_loadValid", 32'(loadValid), 0);
    chk("sh_done_stall", 32'(stall), 0);
    chk("sh_loadData_hold", loadData, 32'hFFFF_8001);
    step();
    chk("sh_idle_loadValid", 32'(loadValid), 0);

    // misaligned lh
    memRead = 1; aluResult = 32'h101;
    #1 chk("mis_stall", 32'(stall), 0);
    step();
    memRead = 0; aluResult = 0;
    chk("mis_pulse", 32'(misaligned), 1);
    chk("mis_busReq", 32'(busReq), 0);
    step();
    chk("mis_pulse_end", 32'(misaligned), 0);

    // timeout: no ack ever
    memRead = 1; aluResult = 32'h300; busRData = 32'h1234_5678;
    step();
    memRead = 0; aluResult = 0;
    n = 0;
    while (busReq && n < 10) begin
      n++;
      step();
    end
    chk("to_req_cycles", 32'(n), 4);
    chk("to_busError", 32'(busError), 1);
    chk("to_stall", 32'(stall), 0);
    step();
    chk("to_busError_end", 32'(busError), 0);
    chk("to_loadData_hold", loadData, 32'hFFFF_8001);
    chk("to_loadValid", 32'(loadValid), 0);

    // memRead and memWrite together: read wins
    memRead = 1; memWrite = 1; aluResult = 32'h0; busRData = 32'h0000_7FFF;
    exp_q.push_back(32'h0000_7FFF);
    step();
    memRead = 0; memWrite = 0;
    chk("both_busWe", 32'(busWe), 0);
    chk("both_byteEn", 32'(busByteEn), 32'h3);
    busAck = 1;
    step();
    busAck = 0;
    chk("both_loadValid", 32'(loadValid), 1);
    pop_load("both");
    step();

    // reset in the middle of REQ
    memWrite = 1; aluResult = 32'h400; writeData = 32'h0000_1111;
    step();
    memWrite = 0; aluResult = 0;
    chk("mid_busReq_before", 32'(busReq), 1);
    #2 resetN = 1'b0;
    #1;
    chk("mid_busReq", 32'(busReq), 0);
    chk("mid_stall", 32'(stall), 0);
    chk("mid_loadData", loadData, 0);
    chk("mid_bus", busAddr | busWData | {28'd0, busByteEn} | {31'd0, busWe}, 0);
    #3 resetN = 1'b1;
    step();
    chk("mid_after_busReq", 32'(busReq), 0);
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
